// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - states, opcodes and control-bit indices for the ALU step sequencer
// Defining ALU_SEQ_MULDIV_EN adds the T6 state used by MUL/DIV.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6
`ifdef ALU_SEQ_MULDIV_EN
        ,
        T6   = 3'd7
`endif
    } state_e;

    localparam logic [4:0] ADD = 5'h03;
    localparam logic [4:0] SUB = 5'h04;
    localparam logic [4:0] AND = 5'h05;
    localparam logic [4:0] OR  = 5'h06;
    localparam logic [4:0] MUL = 5'h0F;
    localparam logic [4:0] DIV = 5'h10;

    // Bit positions shared by the enable and bus_select vectors.
    localparam int HI_EN   = 16;
    localparam int LO_EN   = 17;
    localparam int ZHI_OUT = 18;
    localparam int ZLO_OUT = 19;
    localparam int PC_OUT  = 20;
    localparam int PC_EN   = 20;
    localparam int MDR_OUT = 21;
    localparam int MDR_EN  = 21;
    localparam int IR_EN   = 23;
    localparam int Z_EN    = 24;
    localparam int MAR_EN  = 25;
    localparam int Y_EN    = 27;

    localparam int REG_FIELD_W = 4;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational decode of sequencer state and latched IR fields
// ALU_SEQ_MULDIV_EN makes MUL/DIV legal and decodes the T6 (HI write-back) step.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int CTRL_W   = 32,
    parameter int OP_W     = 5
) (
    input  logic [2:0]             state_i,
    input  logic [OP_W-1:0]        opcode_i,
    input  logic [REG_FIELD_W-1:0] ra_i,
    input  logic [REG_FIELD_W-1:0] rb_i,
    input  logic [REG_FIELD_W-1:0] rc_i,
    output logic [CTRL_W-1:0]      enable_o,
    output logic [CTRL_W-1:0]      bus_select_o,
    output logic [OP_W-1:0]        alu_op_o,
    output logic                   mr_read_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    logic legal_op;
    logic muldiv;
    logic legal_regs;
    logic legal;

    function automatic logic [CTRL_W-1:0] onehot(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

    always_comb begin
        legal_op = (opcode_i == OP_W'(ADD)) || (opcode_i == OP_W'(SUB)) ||
                   (opcode_i == OP_W'(AND)) || (opcode_i == OP_W'(OR));
`ifdef ALU_SEQ_MULDIV_EN
        muldiv   = (opcode_i == OP_W'(MUL)) || (opcode_i == OP_W'(DIV));
`else
        muldiv   = 1'b0;
`endif
        legal_regs = (32'(ra_i) < NUM_REGS) && (32'(rb_i) < NUM_REGS) &&
                     (32'(rc_i) < NUM_REGS);
        legal      = (legal_op || muldiv) && legal_regs;
    end

    always_comb begin
        enable_o     = '0;
        bus_select_o = '0;
        alu_op_o     = '0;
        mr_read_o    = 1'b0;
        busy_o       = (state_i != IDLE);
        done_o       = 1'b0;
        err_o        = 1'b0;
        case (state_i)
            T0: begin
                bus_select_o = onehot(PC_OUT);
                enable_o     = onehot(MAR_EN) | onehot(PC_EN);
            end
            T1: begin
                mr_read_o = 1'b1;
                enable_o  = onehot(MDR_EN);
            end
            T2: begin
                bus_select_o = onehot(MDR_OUT);
                enable_o     = onehot(IR_EN);
            end
            T3: begin
                if (!legal) begin
                    err_o = 1'b1;
                end else begin
                    bus_select_o = onehot(int'(rb_i));
                    enable_o     = onehot(Y_EN);
                end
            end
            T4: begin
                bus_select_o = onehot(int'(rc_i));
                enable_o     = onehot(Z_EN);
                alu_op_o     = opcode_i;
            end
            T5: begin
                // MUL/DIV write the low half here and finish in T6.
                bus_select_o = onehot(ZLO_OUT);
                enable_o     = muldiv ? onehot(LO_EN) : onehot(int'(ra_i));
                done_o       = !muldiv;
            end
`ifdef ALU_SEQ_MULDIV_EN
            T6: begin
                bus_select_o = onehot(ZHI_OUT);
                enable_o     = onehot(HI_EN);
                done_o       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_step_sequencer.sv
// rtl/alu_step_sequencer.sv - Moore control sequencer for fetch/decode/execute of one ALU instruction
// ALU_SEQ_MULDIV_EN enables MUL/DIV (LO in T5, HI in T6); otherwise they raise err.
module alu_step_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int CTRL_W   = 32,
    parameter int OP_W     = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] ir_q,
    output logic [CTRL_W-1:0] enable,
    output logic [CTRL_W-1:0] bus_select,
    output logic              MR_Read,
    output logic [OP_W-1:0]   alu_op,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int RA_MSB = DATA_W - OP_W - 1;
    localparam int RB_MSB = RA_MSB - REG_FIELD_W;
    localparam int RC_MSB = RB_MSB - REG_FIELD_W;

    state_e                 state_q, state_d;
    logic [OP_W-1:0]        opcode_q, opcode_d;
    logic [REG_FIELD_W-1:0] ra_q, ra_d;
    logic [REG_FIELD_W-1:0] rb_q, rb_d;
    logic [REG_FIELD_W-1:0] rc_q, rc_d;

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[RC_MSB-REG_FIELD_W:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
        end
    end

    // IR is loaded during T2, so its fields are captured on the edge into T3.
    always_comb begin
        opcode_d = opcode_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        if (state_q == T2) begin
            opcode_d = ir_q[DATA_W-1 -: OP_W];
            ra_d     = ir_q[RA_MSB -: REG_FIELD_W];
            rb_d     = ir_q[RB_MSB -: REG_FIELD_W];
            rc_d     = ir_q[RC_MSB -: REG_FIELD_W];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = T0;
            T0:   state_d = T1;
            T1:   if (mem_rdy) state_d = T2;
            T2:   state_d = T3;
            T3:   state_d = err ? IDLE : T4;
            T4:   state_d = T5;
`ifdef ALU_SEQ_MULDIV_EN
            T5:   state_d = done ? IDLE : T6;
            T6:   state_d = IDLE;
`else
            T5:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    alu_seq_decode #(
        .NUM_REGS(NUM_REGS),
        .CTRL_W  (CTRL_W),
        .OP_W    (OP_W)
    ) u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_q),
        .ra_i        (ra_q),
        .rb_i        (rb_q),
        .rc_i        (rc_q),
        .enable_o    (enable),
        .bus_select_o(bus_select),
        .alu_op_o    (alu_op),
        .mr_read_o   (MR_Read),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

endmodule

// File: tb/tb_alu_step_sequencer.sv
// tb/tb_alu_step_sequencer.sv - self-checking bench for alu_step_sequencer
`timescale 1ns/1ps
module tb_alu_step_sequencer;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int CTRL_W   = 32;
    localparam int OP_W     = 5;
`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic              mem_rdy;
    logic [DATA_W-1:0] ir_q;
    logic [CTRL_W-1:0] enable;
    logic [CTRL_W-1:0] bus_select;
    logic              MR_Read;
    logic [OP_W-1:0]   alu_op;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    alu_step_sequencer #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CTRL_W(CTRL_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir_q(ir_q),
        .enable(enable), .bus_select(bus_select), .MR_Read(MR_Read), .alu_op(alu_op),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [31:0] en;
        logic [31:0] bs;
        logic        rd;
        logic [4:0]  op;
        logic        bsy;
        logic        dn;
        logic        er;
        logic        drv_rdy;
        logic        drv_start;
    } cyc_t;

    typedef struct {
        string       nm;
        logic [31:0] ir;
        int          waits;
        int          done_at;
        int          err_at;
    } vec_t;

    cyc_t exp_q[$];
    int   t2_idx;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] bit1(input int i);
        return 32'd1 << i;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic cyc_t mk(input logic [31:0] en, input logic [31:0] bs, input logic rd,
                                input logic [4:0] op, input logic dn, input logic er,
                                input logic drv_rdy, input logic drv_start);
        cyc_t c;
        c.en = en; c.bs = bs; c.rd = rd; c.op = op; c.bsy = 1'b1;
        c.dn = dn; c.er = er; c.drv_rdy = drv_rdy; c.drv_start = drv_start;
        return c;
    endfunction

    // Expected per-cycle outputs for one instruction, starting with the cycle after start is taken.
    task automatic build_expect(input logic [31:0] ir, input int waits);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         is_md, ok_op, ok_regs;
        cyc_t       idle_c;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        is_md   = (op == 5'h0F) || (op == 5'h10);
        ok_op   = (op inside {5'h03, 5'h04, 5'h05, 5'h06}) || (MULDIV && is_md);
        ok_regs = (int'(ra) < NUM_REGS) && (int'(rb) < NUM_REGS) && (int'(rc) < NUM_REGS);
        exp_q.delete();
        exp_q.push_back(mk(bit1(25) | bit1(20), bit1(20), 1'b0, 5'd0, 1'b0, 1'b0, rbit(), rbit()));
        for (int w = 0; w <= waits; w++)
            exp_q.push_back(mk(bit1(21), 32'd0, 1'b1, 5'd0, 1'b0, 1'b0, (w == waits), rbit()));
        t2_idx = exp_q.size();
        exp_q.push_back(mk(bit1(23), bit1(21), 1'b0, 5'd0, 1'b0, 1'b0, rbit(), 1'b1));
        if (!(ok_op && ok_regs)) begin
            exp_q.push_back(mk(32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, rbit(), rbit()));
        end else begin
            exp_q.push_back(mk(bit1(27), bit1(rb), 1'b0, 5'd0, 1'b0, 1'b0, rbit(), rbit()));
            exp_q.push_back(mk(bit1(24), bit1(rc), 1'b0, op, 1'b0, 1'b0, rbit(), rbit()));
            if (is_md) begin
                exp_q.push_back(mk(bit1(17), bit1(19), 1'b0, 5'd0, 1'b0, 1'b0, rbit(), rbit()));
                exp_q.push_back(mk(bit1(16), bit1(18), 1'b0, 5'd0, 1'b1, 1'b0, rbit(), rbit()));
            end else begin
                exp_q.push_back(mk(bit1(ra), bit1(19), 1'b0, 5'd0, 1'b1, 1'b0, rbit(), rbit()));
            end
        end
        idle_c = mk(32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, rbit(), 1'b0);
        idle_c.bsy = 1'b0;
        exp_q.push_back(idle_c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string nm, input int idx, input cyc_t e);
        n_checks++;
        if (enable !== e.en || bus_select !== e.bs || MR_Read !== e.rd || alu_op !== e.op ||
            busy !== e.bsy || done !== e.dn || err !== e.er || $countones(bus_select) > 1) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got en=%h bs=%h rd=%b op=%h busy=%b done=%b err=%b, want en=%h bs=%h rd=%b op=%h busy=%b done=%b err=%b",
                     nm, idx, enable, bus_select, MR_Read, alu_op, busy, done, err,
                     e.en, e.bs, e.rd, e.op, e.bsy, e.dn, e.er);
        end
    endtask

    task automatic check_idle(input string nm);
        cyc_t z;
        z = mk(32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        z.bsy = 1'b0;
        check_cycle(nm, 0, z);
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ir, input int waits,
                             output int done_at, output int err_at, output int n_done);
        build_expect(ir, waits);
        ir_q = ir; start = 1'b1; mem_rdy = rbit();
        tick();
        done_at = 0; err_at = 0; n_done = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_rdy = exp_q[i].drv_rdy;
            start   = exp_q[i].drv_start;
            if (i > t2_idx) ir_q = $urandom;
            check_cycle(nm, i + 1, exp_q[i]);
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = i + 1;
            end
            if (err && err_at == 0) err_at = i + 1;
            tick();
        end
        start = 1'b0;
    endtask

    vec_t vt[8];
    int   d_at, e_at, nd;

    initial begin
        vt[0] = '{"sub_r1_r4_r5", 32'h20A28000, 0, 6, 0};
        vt[1] = '{"sub_wait3", 32'h20A28000, 3, 9, 0};
        vt[2] = '{"illegal_op", mk_ir(5'h1F, 4'd1, 4'd2, 4'd3), 0, 0, 4};
        vt[3] = '{"ra15_over", mk_ir(5'h03, 4'd15, 4'd1, 4'd2), 0, 0, 4};
        vt[4] = '{"mul_r1_r2_r3", mk_ir(5'h0F, 4'd1, 4'd2, 4'd3), 0, MULDIV ? 7 : 0, MULDIV ? 0 : 4};
        vt[5] = '{"add_r7_edge", mk_ir(5'h03, 4'd7, 4'd0, 4'd7), 0, 6, 0};
        vt[6] = '{"or_rc8_over", mk_ir(5'h06, 4'd2, 4'd3, 4'd8), 0, 0, 4};
        vt[7] = '{"and_wait1", mk_ir(5'h05, 4'd0, 4'd6, 4'd5), 1, 7, 0};

        clr = 1'b1; start = 1'b0; mem_rdy = 1'b0; ir_q = '0;
        tick(); tick();
        check_idle("reset");
        clr = 1'b0;
        tick();
        check_idle("idle_hold");

        for (int v = 0; v < 8; v++) begin
            run_instr(vt[v].nm, vt[v].ir, vt[v].waits, d_at, e_at, nd);
            check_int({vt[v].nm, " done_at"}, d_at, vt[v].done_at);
            check_int({vt[v].nm, " err_at"}, e_at, vt[v].err_at);
            check_int({vt[v].nm, " n_done"}, nd, (vt[v].done_at != 0) ? 1 : 0);
        end

        // clr in T4 aborts the instruction; a fresh start then runs to completion.
        build_expect(32'h20A28000, 0);
        ir_q = 32'h20A28000; mem_rdy = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_cycle("clr_t4_pre", i + 1, exp_q[i]);
            tick();
        end
        check_cycle("clr_t4_in_t4", 5, exp_q[4]);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_idle("clr_t4_after");
        run_instr("after_clr", 32'h20A28000, 0, d_at, e_at, nd);
        check_int("after_clr done_at", d_at, 6);

        // clr during a T1 memory wait.
        build_expect(32'h20A28000, 5);
        start = 1'b1;
        tick();
        start = 1'b0; mem_rdy = 1'b0;
        check_cycle("clr_t1_t0", 1, exp_q[0]);
        tick();
        check_cycle("clr_t1_wait", 2, exp_q[1]);
        tick();
        check_cycle("clr_t1_wait", 3, exp_q[2]);
        clr = 1'b1;
        tick();
        clr = 1'b0; mem_rdy = 1'b1;
        check_idle("clr_t1_after");
        tick();
        check_idle("clr_t1_stay");

        // clr wins over start on the same edge.
        clr = 1'b1; start = 1'b1;
        tick();
        clr = 1'b0; start = 1'b0;
        check_idle("clr_over_start");

        for (int r = 0; r < 40; r++) begin
            logic [4:0]  op;
            logic [3:0]  ra, rb, rc;
            logic [4:0]  ops[6];
            int          sel;
            ops = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h0F, 5'h10};
            sel = $urandom_range(0, 7);
            op  = (sel < 6) ? ops[sel] : 5'($urandom_range(0, 31));
            ra  = 4'($urandom_range(0, (r % 4 == 0) ? 15 : 7));
            rb  = 4'($urandom_range(0, (r % 5 == 0) ? 15 : 7));
            rc  = 4'($urandom_range(0, (r % 6 == 0) ? 15 : 7));
            run_instr("random", {op, ra, rb, rc, 15'($urandom)}, $urandom_range(0, 3), d_at, e_at, nd);
            check_int("random n_done_le1", (nd <= 1) ? 1 : 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_step_sequencer.md
ALU_STEP_SEQUENCER -- requirements
Module: alu_step_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath and instruction word width.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning general-purpose registers addressable; legal values 2..16.
REQ-003 SHALL have parameter CTRL_W, default 32, meaning width of the enable and bus_select vectors.
REQ-004 SHALL have parameter OP_W, default 5, meaning width of the opcode and alu_op fields.
REQ-005 SHALL have ports: clk in 1, system clock; clr in 1, reset. The block uses one clock, clk; clr is synchronous and active-high.
REQ-006 SHALL have ports: start in 1, begin one instruction; mem_rdy in 1, memory data valid on MDataIn this cycle; ir_q in DATA_W, current IR contents.
REQ-007 SHALL have ports: enable out CTRL_W, one-hot-per-step register load strobes; bus_select out CTRL_W, bus source select, at most one bit set; MR_Read out 1; alu_op out OP_W; busy out 1; done out 1, one-cycle pulse; err out 1, one-cycle pulse.

Function
REQ-010 SHALL be a Moore FSM, states IDLE, T0, T1, T2, T3, T4, T5, T6; outputs decoded from the state register and latched IR fields.
REQ-011 IR fields: opcode [DATA_W-1:DATA_W-OP_W]; Ra (dest) next 4 bits; Rb (src1) next 4; Rc (src2) next 4.
REQ-012 IDLE: all outputs 0; start=1 -> T0 next edge; start while not IDLE SHALL be ignored.
REQ-013 T0: bus_select[PC_OUT], enable[MAR_EN], enable[PC_EN] (increment); -> T1.
REQ-014 T1: MR_Read=1, enable[MDR_EN]; stays in T1 while mem_rdy=0; mem_rdy=1 -> T2.
REQ-015 T2: bus_select[MDR_OUT], enable[IR_EN]; -> T3; Ra/Rb/Rc/opcode captured from ir_q at the T3 entry edge.
REQ-016 T3 entry decode: opcode not in legal set, or Ra/Rb/Rc >= NUM_REGS -> err pulse during T3, all other outputs 0, -> IDLE, no done.
REQ-017 T3 (legal): bus_select[Rb], enable[Y_EN]; -> T4.
REQ-018 T4: bus_select[Rc], enable[Z_EN], alu_op=opcode; alu_op SHALL be 0 in every other state; -> T5.
REQ-019 T5: bus_select[ZLO_OUT]; enable[Ra], or enable[LO_EN] for MUL/DIV; -> T6 for MUL/DIV, else -> IDLE with done=1 in T5.
REQ-020 T6: bus_select[ZHI_OUT], enable[HI_EN], done=1; -> IDLE.
REQ-021 busy=1 in every state except IDLE.
REQ-022 Latency, no memory wait: start at edge n -> done high in cycle n+6 (ALU ops) or n+7 (MUL/DIV); each mem_rdy=0 cycle in T1 adds one.
REQ-023 bus_select SHALL never have more than one bit set in any cycle.

Reset
REQ-030 clr=1 at a rising edge SHALL force IDLE and clear latched fields; all outputs 0 the following cycle, including mid-instruction and during a T1 wait.
REQ-031 clr SHALL take priority over start in the same cycle.

Configuration
REQ-040 Macro ALU_SEQ_MULDIV_EN: when defined, MUL/DIV are legal and use T5 (LO) plus T6 (HI).
REQ-041 Without ALU_SEQ_MULDIV_EN: T6 SHALL not exist, and MUL/DIV opcodes SHALL take the REQ-016 err path.

Structure
REQ-050 Package alu_seq_pkg SHALL hold: state enum; opcode constants ADD=5'h03, SUB=5'h04, AND=5'h05, OR=5'h06, MUL=5'h0F, DIV=5'h10; enable/select index constants HI_EN=16, LO_EN=17, ZHI_OUT=18, ZLO_OUT=19, PC_OUT=PC_EN=20, MDR_OUT=MDR_EN=21, IR_EN=23, Z_EN=24, MAR_EN=25, Y_EN=27; registers use indices 0..NUM_REGS-1.
REQ-051 One sub-module, alu_seq_decode, SHALL be combinational: state + fields -> enable, bus_select, alu_op.

Verification
REQ-060 SUB R1,R4,R5: ir_q=0x20A28000, mem_rdy=1, start -> T3 bus_select[4]+enable[27]; T4 bus_select[5]+enable[24]+alu_op=5'h04; T5 bus_select[19]+enable[1]; done at start+6.
REQ-061 Memory wait: mem_rdy held 0 for 3 cycles in T1 -> MR_Read stays 1 for 4 cycles, done at start+9.
REQ-062 Illegal opcode 5'h1F -> err pulse in T3, no done, IDLE next cycle; Ra=15 with NUM_REGS=8 -> err.
REQ-063 clr asserted in T4 -> all outputs 0 next cycle, busy=0; new start runs a full sequence.
REQ-064 MUL R2,R3 (opcode 5'h0F): with ALU_SEQ_MULDIV_EN, T5 enable[17], T6 bus_select[18]+enable[16], done at start+7; without it, err.
REQ-065 start pulsed during T2 -> ignored, exactly one done.
